// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg -- shared constants and types for the instruction fetch stage.
//   WORD_W       : datapath word width
//   NOP_INSN     : encoding driven on the decode interface when nothing is valid
//   RESET_PC_DEF : default first fetch address after reset
//   fetch_state_e: fetch controller states
package fetch_stage_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- small synchronous FIFO with flush and occupancy count.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data (ignored when full unless popping)
//   pop               : remove the head entry (ignored when empty)
//   flush             : empty the FIFO; overrides push and pop
//   head              : current head entry (meaningless when empty)
//   count, empty, full: occupancy
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));
  assign count     = r_cnt;
  assign head      = r_mem[r_rd];
  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_inc(r_wr);
      if (w_do_pop)  r_rd <= ptr_inc(r_rd);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch: issues word addresses to instruction memory,
// pairs in-order responses with their addresses and buffers them for decode.
// A redirect flushes everything and discards responses still in flight.
//   clk, rst                       : clock, asynchronous active-low reset
//   imemReqValid_o/Addr_o/Ready_i  : fetch request handshake
//   imemRespValid_i/Data_i         : in-order read responses
//   jumpEnable_i, jumpAddr_i       : redirect from execute
//   instruction_o/instructionAddr_o/instValid_o/instReady_i : decode handshake
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imemReqValid_o,
  output logic [WORD_W-1:0] imemReqAddr_o,
  input  logic              imemReqReady_i,
  input  logic              imemRespValid_i,
  input  logic [WORD_W-1:0] imemRespData_i,
  input  logic              jumpEnable_i,
  input  logic [WORD_W-1:0] jumpAddr_i,
  output logic [WORD_W-1:0] instruction_o,
  output logic [WORD_W-1:0] instructionAddr_o,
  output logic              instValid_o,
  input  logic              instReady_i
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e        r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_pc;
  logic [CW-1:0]       r_discard, w_discard_nxt;

  logic [WORD_W-1:0]   w_aq_head;
  logic [CW-1:0]       w_aq_cnt;
  logic                w_aq_empty, w_aq_full;
  logic [2*WORD_W-1:0] w_buf_head;
  logic [CW-1:0]       w_buf_cnt;
  logic                w_buf_empty, w_buf_full;

  logic [CW:0]         w_occ;
  logic [CW:0]         w_inflight;
  logic [CW:0]         w_discard_load;
  logic [WORD_W-1:0]   w_jump_tgt;
  logic                w_req_fire, w_resp_live, w_consume;

  assign w_jump_tgt = jumpAddr_i & 32'hFFFF_FFFC;
  assign w_occ      = {1'b0, w_aq_cnt} + {1'b0, w_buf_cnt};
  assign w_inflight = {1'b0, w_aq_cnt} + {1'b0, r_discard};
  // A response landing in the redirect cycle is dropped here, so it is not
  // counted again; a response with nothing in flight must not underflow.
  assign w_discard_load = (imemRespValid_i && w_inflight != '0) ? w_inflight - 1'b1 : w_inflight;

  assign imemReqValid_o = (r_state == ST_RUN) && !jumpEnable_i && !w_aq_full &&
                          (w_occ < (CW+1)'(DEPTH));
  assign imemReqAddr_o  = r_pc;
  assign w_req_fire     = imemReqValid_o && imemReqReady_i;

  // Responses are kept only outside a drain, never in a redirect cycle, and
  // only when an address is waiting for them (stray responses are ignored).
  assign w_resp_live = imemRespValid_i && !jumpEnable_i && (r_discard == '0) &&
                       !w_aq_empty && (!w_buf_full || w_consume);

  assign instValid_o       = !w_buf_empty && (r_state != ST_DRAIN);
  assign w_consume         = instValid_o && instReady_i;
  assign instruction_o     = instValid_o ? w_buf_head[WORD_W-1:0] : NOP_INSN;
  assign instructionAddr_o = instValid_o ? w_buf_head[2*WORD_W-1:WORD_W] : '0;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_req_fire),
    .push_data (r_pc),
    .pop       (w_resp_live),
    .flush     (jumpEnable_i),
    .head      (w_aq_head),
    .count     (w_aq_cnt),
    .empty     (w_aq_empty),
    .full      (w_aq_full)
  );

  sync_fifo #(.WIDTH(2*WORD_W), .DEPTH(DEPTH)) u_ibuf (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_resp_live),
    .push_data ({w_aq_head, imemRespData_i}),
    .pop       (w_consume),
    .flush     (jumpEnable_i),
    .head      (w_buf_head),
    .count     (w_buf_cnt),
    .empty     (w_buf_empty),
    .full      (w_buf_full)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    if (jumpEnable_i) begin
      w_discard_nxt = CW'(w_discard_load);
      w_state_nxt   = (w_discard_load != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      unique case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        ST_DRAIN: begin
          if (r_discard == '0) begin
            w_state_nxt = ST_RUN;
          end else if (imemRespValid_i) begin
            w_discard_nxt = r_discard - 1'b1;
            if (r_discard == CW'(1)) w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_BOOT;
      r_discard <= '0;
      r_pc      <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      if (jumpEnable_i)    r_pc <= w_jump_tgt;
      else if (w_req_fire) r_pc <= r_pc + 32'd4;
    end
  end

endmodule
